// File: rtl/host_loader_if.sv
// Host word stream plus controller request/acknowledge signals for host_loader.
interface host_loader_if #(
  parameter int TGT_WORDS = 8,
  parameter int MSG_WORDS = 19
);
  logic                       in_valid;
  logic                       in_ready;
  logic [31:0]                in_data;
  logic                       loadTarget;
  logic                       loadMsg;
  logic                       newTarget;
  logic                       newMsg;
  logic [32*TGT_WORDS-1:0]    target_data;
  logic [32*MSG_WORDS-1:0]    msg_data;
  logic                       cmd_error;

  modport master (
    output in_valid, in_data, loadTarget, loadMsg,
    input  in_ready, newTarget, newMsg, target_data, msg_data, cmd_error
  );

  modport slave (
    input  in_valid, in_data, loadTarget, loadMsg,
    output in_ready, newTarget, newMsg, target_data, msg_data, cmd_error
  );
endinterface

// File: rtl/host_loader.sv
// Host ingress stage: decodes command words and assembles the difficulty target
// or block-header prefix, holding a request until the controller acknowledges.
module host_loader #(
  parameter int TGT_WORDS = 8,
  parameter int MSG_WORDS = 19
) (
  input  logic         clk,
  input  logic         n_rst,
  host_loader_if.slave bus
);
  localparam int          TGT_W    = 32 * TGT_WORDS;
  localparam int          MSG_W    = 32 * MSG_WORDS;
  localparam logic [4:0]  TGT_LAST = 5'(TGT_WORDS - 1);
  localparam logic [4:0]  MSG_LAST = 5'(MSG_WORDS - 1);
  localparam logic [31:0] OP_TGT   = 32'h0000_0001;
  localparam logic [31:0] OP_MSG   = 32'h0000_0002;

  typedef enum logic [2:0] {
    ST_CMD      = 3'd0,
    ST_RX_TGT   = 3'd1,
    ST_RX_MSG   = 3'd2,
    ST_PEND_TGT = 3'd3,
    ST_PEND_MSG = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [4:0]       cnt_r, cnt_s;
  logic [TGT_W-1:0] tgt_buf_r;
  logic [MSG_W-1:0] msg_buf_r;
  logic             cmd_error_r, cmd_error_s;
  logic             tgt_shift_s, msg_shift_s;
  logic             in_ready_s, accept_s;

  assign in_ready_s = (state_r == ST_CMD) || (state_r == ST_RX_TGT) || (state_r == ST_RX_MSG);
  assign accept_s   = bus.in_valid & in_ready_s;

  // State, word counter and error-pulse registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r     <= ST_CMD;
      cnt_r       <= 5'd0;
      cmd_error_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      cmd_error_r <= cmd_error_s;
    end
  end

  // Next-state, counter and shift-enable decode
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    cmd_error_s = 1'b0;
    tgt_shift_s = 1'b0;
    msg_shift_s = 1'b0;
    case (state_r)
      ST_CMD: begin
        if (accept_s) begin
          cnt_s = 5'd0;
          if (bus.in_data == OP_TGT) begin
            state_s = ST_RX_TGT;
          end else if (bus.in_data == OP_MSG) begin
            state_s = ST_RX_MSG;
          end else begin
            cmd_error_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_RX_TGT: begin
        if (accept_s) begin
          tgt_shift_s = 1'b1;
          cnt_s       = cnt_r + 5'd1;
          if (cnt_r == TGT_LAST) begin
            state_s = ST_PEND_TGT;
          end else begin
            state_s = ST_RX_TGT;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_RX_MSG: begin
        if (accept_s) begin
          msg_shift_s = 1'b1;
          cnt_s       = cnt_r + 5'd1;
          if (cnt_r == MSG_LAST) begin
            state_s = ST_PEND_MSG;
          end else begin
            state_s = ST_RX_MSG;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      // Only the matching acknowledge releases a pending block
      ST_PEND_TGT: begin
        if (bus.loadTarget) begin
          state_s = ST_CMD;
        end else begin
          state_s = ST_PEND_TGT;
        end
      end
      ST_PEND_MSG: begin
        if (bus.loadMsg) begin
          state_s = ST_CMD;
        end else begin
          state_s = ST_PEND_MSG;
        end
      end
      default: begin
        state_s = ST_CMD;
        cnt_s   = 5'd0;
      end
    endcase
  end

  // Payload shift buffers; first word ends up in the MSBs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tgt_buf_r <= '0;
      msg_buf_r <= '0;
    end else begin
      if (tgt_shift_s) begin
        tgt_buf_r <= {tgt_buf_r[TGT_W-33:0], bus.in_data};
      end
      if (msg_shift_s) begin
        msg_buf_r <= {msg_buf_r[MSG_W-33:0], bus.in_data};
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.newTarget   = (state_r == ST_PEND_TGT);
  assign bus.newMsg      = (state_r == ST_PEND_MSG);
  assign bus.target_data = tgt_buf_r;
  assign bus.msg_data    = msg_buf_r;
  assign bus.cmd_error   = cmd_error_r;
endmodule

// File: tb/tb_host_loader.sv
// Self-checking bench for host_loader: randomized frames compared against a
// word-list reference model of the assembled target and header prefix.
module tb_host_loader;
  localparam int TGT_WORDS = 8;
  localparam int MSG_WORDS = 19;
  localparam int TGT_W     = 32 * TGT_WORDS;
  localparam int MSG_W     = 32 * MSG_WORDS;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  host_loader_if #(.TGT_WORDS(TGT_WORDS), .MSG_WORDS(MSG_WORDS)) bus();

  host_loader #(.TGT_WORDS(TGT_WORDS), .MSG_WORDS(MSG_WORDS)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0]      pay_q[$];
  logic [TGT_W-1:0] exp_tgt;
  logic [MSG_W-1:0] exp_msg;

  // Reference: word i of an n-word block occupies bits 32*(n-1-i) +: 32
  function automatic logic [MSG_W-1:0] pack_words(input int n);
    logic [MSG_W-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[32*(n-1-i) +: 32] = pay_q[i];
    return v;
  endfunction

  task automatic gen_random(input int n);
    pay_q.delete();
    repeat (n) pay_q.push_back($urandom);
  endtask

  function automatic logic [31:0] bad_opcode();
    logic [31:0] op;
    op = $urandom;
    if (op == 32'd1 || op == 32'd2) op = op + 32'd3;
    return op;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge
  task automatic send_word(input logic [31:0] d, input int gap);
    int t;
    t = 0;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      bus.in_data = $urandom;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout in_ready=%b required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] cmd, input int n, input int gap_max);
    send_word(cmd, $urandom_range(0, gap_max));
    for (int i = 0; i < n; i++) send_word(pay_q[i], $urandom_range(0, gap_max));
  endtask

  task automatic pulse_load(input logic t, input logic m);
    bus.loadTarget = t;
    bus.loadMsg    = m;
    @(negedge clk);
    bus.loadTarget = 1'b0;
    bus.loadMsg    = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = 32'h0; bus.loadTarget = 1'b0; bus.loadMsg = 1'b0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    exp_tgt = '0;
    exp_msg = '0;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    tests++; if (bus.newTarget !== 1'b0) begin fails++; $display("FAIL reset_newTarget got %b want 0", bus.newTarget); end
    tests++; if (bus.newMsg !== 1'b0) begin fails++; $display("FAIL reset_newMsg got %b want 0", bus.newMsg); end
    tests++; if (bus.cmd_error !== 1'b0) begin fails++; $display("FAIL reset_cmd_error got %b want 0", bus.cmd_error); end
    tests++; if (bus.target_data !== exp_tgt) begin fails++; $display("FAIL reset_target_data got %h want 0", bus.target_data); end
    tests++; if (bus.msg_data !== exp_msg) begin fails++; $display("FAIL reset_msg_data got %h want 0", bus.msg_data); end
  endtask

  task automatic test_target_load();
    logic [TGT_W-1:0] want;
    int hold;
    want = {32'h0000_000F, {7{32'hFFFF_FFFF}}};
    pay_q.delete();
    pay_q.push_back(32'h0000_000F);
    repeat (7) pay_q.push_back(32'hFFFF_FFFF);
    send_word(32'h0000_0001, 0);
    for (int i = 0; i < TGT_WORDS - 1; i++) send_word(pay_q[i], 0);
    tests++; if (bus.newTarget !== 1'b0) begin fails++; $display("FAIL tgt_early_newTarget got %b want 0", bus.newTarget); end
    send_word(pay_q[TGT_WORDS-1], 0);
    exp_tgt = want;
    tests++; if (bus.newTarget !== 1'b1) begin fails++; $display("FAIL tgt_cycle9_newTarget got %b want 1", bus.newTarget); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL tgt_pend_in_ready got %b want 0", bus.in_ready); end
    tests++; if (bus.target_data !== want) begin fails++; $display("FAIL tgt_data got %h want %h", bus.target_data, want); end
    // Host keeps offering words while pending; none may be taken
    hold = $urandom_range(2, 6);
    bus.in_valid = 1'b1;
    repeat (hold) begin
      bus.in_data = $urandom;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    tests++; if (bus.newTarget !== 1'b1 || bus.target_data !== exp_tgt) begin
      fails++; $display("FAIL tgt_hold newTarget=%b data=%h want 1 %h", bus.newTarget, bus.target_data, exp_tgt);
    end
    tests++; if (bus.msg_data !== exp_msg) begin fails++; $display("FAIL tgt_msg_untouched got %h want %h", bus.msg_data, exp_msg); end
    pulse_load(1'b1, 1'b0);
    tests++; if (bus.newTarget !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL tgt_ack newTarget=%b in_ready=%b want 0 1", bus.newTarget, bus.in_ready);
    end
  endtask

  task automatic test_message_stalls();
    logic [MSG_W-1:0] got;
    pay_q.delete();
    for (int i = 1; i <= MSG_WORDS; i++) pay_q.push_back(32'(i));
    send_word(32'h0000_0002, 1);
    for (int i = 0; i < MSG_WORDS - 1; i++) send_word(pay_q[i], 1);
    tests++; if (bus.newMsg !== 1'b0) begin fails++; $display("FAIL msg_early_newMsg got %b want 0", bus.newMsg); end
    send_word(pay_q[MSG_WORDS-1], 1);
    exp_msg = pack_words(MSG_WORDS);
    got = bus.msg_data;
    tests++; if (bus.newMsg !== 1'b1 || bus.newTarget !== 1'b0) begin
      fails++; $display("FAIL msg_pending newMsg=%b newTarget=%b want 1 0", bus.newMsg, bus.newTarget);
    end
    tests++; if (got[607:576] !== 32'h0000_0001) begin fails++; $display("FAIL msg_first_word got %h want 00000001", got[607:576]); end
    tests++; if (got[31:0] !== 32'h0000_0013) begin fails++; $display("FAIL msg_last_word got %h want 00000013", got[31:0]); end
    tests++; if (got !== exp_msg) begin fails++; $display("FAIL msg_data got %h want %h", got, exp_msg); end
    tests++; if (bus.target_data !== exp_tgt) begin fails++; $display("FAIL msg_tgt_untouched got %h want %h", bus.target_data, exp_tgt); end
    pulse_load(1'b0, 1'b1);
    tests++; if (bus.newMsg !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL msg_ack newMsg=%b in_ready=%b want 0 1", bus.newMsg, bus.in_ready);
    end
  endtask

  task automatic test_bad_opcode();
    logic [31:0]      op;
    logic [MSG_W-1:0] v;
    for (int k = 0; k < 3; k++) begin
      op = (k == 0) ? 32'h0000_0007 : bad_opcode();
      send_word(op, 0);
      tests++; if (bus.cmd_error !== 1'b1 || bus.in_ready !== 1'b1) begin
        fails++; $display("FAIL bad_op_pulse op=%h cmd_error=%b in_ready=%b want 1 1", op, bus.cmd_error, bus.in_ready);
      end
      @(negedge clk);
      tests++; if (bus.cmd_error !== 1'b0) begin fails++; $display("FAIL bad_op_width got %b want 0", bus.cmd_error); end
      gen_random(TGT_WORDS);
      send_frame(32'h0000_0001, TGT_WORDS, 2);
      v = pack_words(TGT_WORDS);
      exp_tgt = v[TGT_W-1:0];
      tests++; if (bus.newTarget !== 1'b1 || bus.target_data !== exp_tgt) begin
        fails++; $display("FAIL bad_op_followup newTarget=%b data=%h want 1 %h", bus.newTarget, bus.target_data, exp_tgt);
      end
      pulse_load(1'b1, 1'b0);
    end
  endtask

  task automatic test_cross_ack();
    logic [MSG_W-1:0] v;
    gen_random(TGT_WORDS);
    send_frame(32'h0000_0001, TGT_WORDS, 1);
    v = pack_words(TGT_WORDS);
    exp_tgt = v[TGT_W-1:0];
    pulse_load(1'b0, 1'b1);
    tests++; if (bus.newTarget !== 1'b1 || bus.newMsg !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL cross_loadMsg newTarget=%b newMsg=%b in_ready=%b want 1 0 0", bus.newTarget, bus.newMsg, bus.in_ready);
    end
    pulse_load(1'b1, 1'b0);
    pulse_load(1'b1, 1'b1);
    tests++; if (bus.in_ready !== 1'b1 || bus.newTarget !== 1'b0 || bus.newMsg !== 1'b0) begin
      fails++; $display("FAIL stray_load_cmd in_ready=%b newTarget=%b newMsg=%b want 1 0 0", bus.in_ready, bus.newTarget, bus.newMsg);
    end
    tests++; if (bus.target_data !== exp_tgt || bus.msg_data !== exp_msg) begin
      fails++; $display("FAIL stray_load_data tgt=%h msg=%h want %h %h", bus.target_data, bus.msg_data, exp_tgt, exp_msg);
    end
    // Acknowledges during reception must not disturb the transfer
    gen_random(MSG_WORDS);
    send_word(32'h0000_0002, 0);
    for (int i = 0; i < 5; i++) send_word(pay_q[i], 0);
    pulse_load(1'b1, 1'b1);
    for (int i = 5; i < MSG_WORDS; i++) send_word(pay_q[i], 0);
    exp_msg = pack_words(MSG_WORDS);
    tests++; if (bus.newMsg !== 1'b1 || bus.msg_data !== exp_msg) begin
      fails++; $display("FAIL stray_load_rx newMsg=%b data=%h want 1 %h", bus.newMsg, bus.msg_data, exp_msg);
    end
    pulse_load(1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    gen_random(MSG_WORDS);
    send_word(32'h0000_0002, 0);
    for (int i = 0; i < 10; i++) send_word(pay_q[i], 0);
    n_rst = 1'b0;
    #1;
    exp_tgt = '0;
    exp_msg = '0;
    tests++; if (bus.in_ready !== 1'b1 || bus.newMsg !== 1'b0 || bus.newTarget !== 1'b0 || bus.cmd_error !== 1'b0) begin
      fails++; $display("FAIL midrst_ctrl in_ready=%b newMsg=%b newTarget=%b cmd_error=%b want 1 0 0 0",
                        bus.in_ready, bus.newMsg, bus.newTarget, bus.cmd_error);
    end
    tests++; if (bus.target_data !== exp_tgt || bus.msg_data !== exp_msg) begin
      fails++; $display("FAIL midrst_data tgt=%h msg=%h want 0 0", bus.target_data, bus.msg_data);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    gen_random(MSG_WORDS);
    send_frame(32'h0000_0002, MSG_WORDS, 1);
    exp_msg = pack_words(MSG_WORDS);
    tests++; if (bus.newMsg !== 1'b1 || bus.msg_data !== exp_msg) begin
      fails++; $display("FAIL midrst_resend newMsg=%b data=%h want 1 %h", bus.newMsg, bus.msg_data, exp_msg);
    end
    pulse_load(1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int               kind;
    int               gmax;
    logic [31:0]      op;
    logic [MSG_W-1:0] v;
    repeat (14) begin
      kind = $urandom_range(0, 2);
      gmax = $urandom_range(0, 2);
      if (kind == 0) begin
        gen_random(TGT_WORDS);
        send_frame(32'h0000_0001, TGT_WORDS, gmax);
        v = pack_words(TGT_WORDS);
        exp_tgt = v[TGT_W-1:0];
        tests++; if (bus.newTarget !== 1'b1 || bus.newMsg !== 1'b0 || bus.target_data !== exp_tgt || bus.msg_data !== exp_msg) begin
          fails++; $display("FAIL b2b_tgt newTarget=%b newMsg=%b tgt=%h want 1 0 %h", bus.newTarget, bus.newMsg, bus.target_data, exp_tgt);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        pulse_load(1'b1, 1'b0);
      end else if (kind == 1) begin
        gen_random(MSG_WORDS);
        send_frame(32'h0000_0002, MSG_WORDS, gmax);
        exp_msg = pack_words(MSG_WORDS);
        tests++; if (bus.newMsg !== 1'b1 || bus.newTarget !== 1'b0 || bus.msg_data !== exp_msg || bus.target_data !== exp_tgt) begin
          fails++; $display("FAIL b2b_msg newMsg=%b newTarget=%b msg=%h want 1 0 %h", bus.newMsg, bus.newTarget, bus.msg_data, exp_msg);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        pulse_load(1'b0, 1'b1);
      end else begin
        op = bad_opcode();
        send_word(op, gmax);
        tests++; if (bus.cmd_error !== 1'b1) begin fails++; $display("FAIL b2b_bad op=%h cmd_error=%b want 1", op, bus.cmd_error); end
      end
      tests++; if (bus.newTarget !== 1'b0 || bus.newMsg !== 1'b0 || bus.in_ready !== 1'b1) begin
        fails++; $display("FAIL b2b_idle newTarget=%b newMsg=%b in_ready=%b want 0 0 1", bus.newTarget, bus.newMsg, bus.in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_target_load();
    test_message_stalls();
    test_bad_opcode();
    test_cross_ack();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/host_loader.md
# host_loader

Host-facing ingress stage that sits directly upstream of the mining controller. Accepts a stream of 32-bit words from the host over a valid/ready handshake and decodes each leading command word. Assembles either a 256-bit difficulty target or the 608-bit block-header prefix (header without nonce), then raises `newTarget`/`newMsg` until the controller acknowledges with `loadTarget`/`loadMsg`. The target and nonce-compare datapath and the message registers latch `target_data`/`msg_data` on those acknowledge pulses.

## Interface
- `TGT_WORDS`, 8: payload words per target command (256 bits)
- `MSG_WORDS`, 19: payload words per message command (608 bits)
- `clk`  in  1  clock, rising-edge
- `n_rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  host word valid
- `in_ready`  out  1  loader can accept a word
- `in_data`  in  32  host word (command or payload)
- `loadTarget`  in  1  controller acknowledge for target
- `loadMsg`  in  1  controller acknowledge for message
- `newTarget`  out  1  complete target pending (level)
- `newMsg`  out  1  complete message pending (level)
- `target_data`  out  32*TGT_WORDS  assembled target; first payload word in MSBs
- `msg_data`  out  32*MSG_WORDS  assembled header prefix; first payload word in MSBs
- `cmd_error`  out  1  one-cycle pulse, unrecognised command word dropped

## Operation
- Transfer occurs on a rising edge where `in_valid & in_ready` are both high. Words are never dropped or duplicated.
- The FSM has five states: CMD, RX_TGT, RX_MSG, PEND_TGT, PEND_MSG. `in_ready` = state ∈ {CMD, RX_TGT, RX_MSG}.
- **CMD:**
  - Accepted word 32'h0000_0001 → RX_TGT.
  - Accepted word 32'h0000_0002 → RX_MSG.
  - Any other accepted word → stay in CMD and pulse `cmd_error` on the next cycle.
  - The word counter clears on every CMD accept.
- **RX_TGT / RX_MSG:**
  - Each accepted word shifts into the matching buffer: buf <= {buf[W-33:0], in_data}.
  - The 5-bit counter increments on each accept.
  - The accept with counter == N-1 moves the FSM to PEND_TGT / PEND_MSG.
  - The other buffer is untouched.
- **PEND_TGT:**
  - `newTarget` = 1 and `in_ready` = 0.
  - `loadTarget` → CMD.
  - `loadMsg` is ignored.
- **PEND_MSG:**
  - `newMsg` = 1 and `in_ready` = 0.
  - `loadMsg` → CMD.
  - `loadTarget` is ignored.
- Loads arriving in CMD/RX states are ignored; no state or buffer change.
- Buffers hold their value after acknowledge until overwritten by the next command of the same type. A message command does not disturb `target_data`, and vice versa.
- `newTarget` and `newMsg` are never high simultaneously.
- Payload words that look like opcodes are treated as data; decoding happens only in CMD.

## Timing
- Reset values:
  - state CMD and counter 0.
  - `in_ready` = 1, `newTarget` = 0, `newMsg` = 0, `cmd_error` = 0.
  - `target_data` = 0, `msg_data` = 0.
- All outputs are decoded from registered state (`cmd_error` is its own flop); there are no combinational input→output paths.
- Latency with back-to-back `in_valid`:
  - Command accepted at edge 0, payload at edges 1..N.
  - `newX` goes high the cycle after edge N: target at cycle 9, message at cycle 20.
- Stalls (`in_valid` low) simply extend the transfer. Counter and buffers hold.
- Acknowledge: `loadX` high at edge k → `newX` low from cycle k+1, `in_ready` high from cycle k+1.
  - This guarantees the controller, back in IDLE after its one-cycle load state, never sees a stale request.
- `newX` held indefinitely while the controller is mining. There is no timeout.
- `n_rst` asserted mid-transfer or while pending:
  - Immediately returns to reset values.
  - The partial payload is discarded.
  - The host must resend the full command.

## Test plan
- **Reset:** after `n_rst` release → `in_ready` = 1, `newTarget` = `newMsg` = 0, `target_data` = 0.
- **Target load:** send 1, then words 0x0000000F, 0xFFFFFFFF ×7 with no gaps.
  - `newTarget` = 1 at cycle 9.
  - `target_data` = 256'h0000000F_FFFF…FFFF.
  - `in_ready` = 0 while pending.
  - `loadTarget` pulse → `newTarget` = 0 next cycle.
- **Message load with stalls:** send 2, then words 0x00000001..0x00000013 with `in_valid` toggling every other cycle.
  - `newMsg` rises after the 19th accept.
  - `msg_data[607:576]` = 1 and `msg_data[31:0]` = 0x13.
  - `target_data` is unchanged.
- **Bad opcode:** send 0x00000007, then 1 plus 8 payload words.
  - `cmd_error` high exactly one cycle after the bad accept.
  - The subsequent target assembles correctly.
- **Cross/stray acknowledge:**
  - `loadMsg` during PEND_TGT → `newTarget` stays 1.
  - `loadTarget` in CMD → no change.
- **Reset mid-message:** assert `n_rst` after 10 payload words.
  - Outputs return to reset values.
  - A following full message command yields the correct `msg_data`.
